// File: rtl/alu_cmd_issuer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issuer_if
// Description : Host-to-issuer command handshake carrying {a, b, sel}.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_issuer_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [1:0]        in_sel;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_sel,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_sel,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issuer
// Description : FIFO-buffered command stage feeding a registered ALU, with a
//               result-valid flag aligned to the ALU's registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer #(
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 4,
    parameter int RES_LAT = 1
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     flush,
    input  wire logic                     hold,
    alu_cmd_issuer_if.slave               cmd,
    output logic [DATA_W-1:0]             alu_a,
    output logic [DATA_W-1:0]             alu_b,
    output logic [1:0]                    alu_sel,
    output logic                          issue,
    output logic                          res_valid,
    output logic [$clog2(DEPTH):0]        count,
    output logic [7:0]                    issued_cnt,
    output logic [1:0]                    state
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_EW = 2 * DATA_W + 2;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    logic [c_EW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   w_count_nxt;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [1:0]        r_alu_sel;
    logic              r_issue;
    logic [7:0]        r_issued_cnt;
    logic [RES_LAT-1:0] r_res_pipe;
    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic [c_EW-1:0]   w_head;

    // No full-bypass: a full FIFO refuses even when a pop happens this cycle.
    assign w_ready      = !reset && !flush && (r_count < c_FULL);
    assign cmd.in_ready = w_ready;
    assign w_push       = cmd.in_valid && w_ready;
    assign w_pop        = (r_count != '0) && !hold && !flush;
    assign w_head       = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd.in_a, cmd.in_b, cmd.in_sel};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_issue      <= 1'b0;
            r_issued_cnt <= '0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_AW'(1);
                end
            end
            r_count <= w_count_nxt;
            r_issue <= w_pop;
            // Without a pop the operands stay put, so the ALU recomputes unflagged.
            if (w_pop) begin
                r_alu_a      <= w_head[c_EW-1 -: DATA_W];
                r_alu_b      <= w_head[DATA_W+1 -: DATA_W];
                r_alu_sel    <= w_head[1:0];
                r_issued_cnt <= r_issued_cnt + 8'd1;
            end
        end
    end

    generate
        if (RES_LAT == 1) begin : g_res_lat1
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    r_res_pipe <= '0;
                end else begin
                    r_res_pipe <= r_issue;
                end
            end
        end else begin : g_res_latn
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    r_res_pipe <= '0;
                end else begin
                    r_res_pipe <= {r_res_pipe[RES_LAT-2:0], r_issue};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // State reflects the occupancy the FIFO will have after this edge.
    always_comb begin
        w_state_nxt = S_IDLE;
        if (!flush && (w_count_nxt != '0)) begin
            w_state_nxt = hold ? S_HOLD : S_RUN;
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign issue      = r_issue;
    assign res_valid  = r_res_pipe[RES_LAT-1];
    assign count      = r_count;
    assign issued_cnt = r_issued_cnt;
    assign state      = r_state;

endmodule
`default_nettype wire
